// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants, fetch FSM encoding and buffer entry layout.
package riscv_pkg;
    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc,instr} buffer with flush; flush wins over push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // a push into a full buffer is only legal alongside a pop
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage; credited word fetches, in-order buffering,
// redirect flush with stale-response draining.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [4:0]      selector,
    output logic            fetch_misalign
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, fifo_count;
    logic            fetch_misalign_q, fetch_misalign_d;
    logic            redirect, accept, drop, push, credit_ok, fifo_full, fifo_empty;
    fetch_entry_t    push_entry, head;

    assign redirect   = redirect_valid && state_q != ST_BOOT;
    assign accept     = imem_req_valid && imem_req_ready;
    assign drop       = imem_rsp_valid && drop_cnt_q != '0;
    assign push       = imem_rsp_valid && !drop;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    // in-flight plus buffered words never exceed the buffer, so a response always fits
    assign credit_ok  = (CW+1)'(outstanding_q) + (CW+1)'(fifo_count) < (CW+1)'(FIFO_DEPTH) && !fifo_full;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_BOOT;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == ST_BOOT ? ST_RUN : drop_cnt_d != '0 ? ST_DRAIN : ST_RUN;
    end

    always_comb begin
        imem_req_valid = state_q == ST_RUN && credit_ok;
        imem_req_addr  = fetch_pc_q;
    end

    // a redirect makes every response still owed by memory stale, including one accepted now
    always_comb begin
        outstanding_d    = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
        drop_cnt_d       = redirect ? outstanding_d : drop_cnt_q - CW'(drop);
        fetch_pc_d       = redirect ? pc_align(redirect_pc) : fetch_pc_q + (accept ? 32'd4 : 32'd0);
        rsp_pc_d         = redirect ? pc_align(redirect_pc) : rsp_pc_q + (push ? 32'd4 : 32'd0);
        fetch_misalign_d = redirect ? |redirect_pc[1:0] : fetch_misalign_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q       <= RESET_PC;
            rsp_pc_q         <= RESET_PC;
            outstanding_q    <= '0;
            drop_cnt_q       <= '0;
            fetch_misalign_q <= 1'b0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            rsp_pc_q         <= rsp_pc_d;
            outstanding_q    <= outstanding_d;
            drop_cnt_q       <= drop_cnt_d;
            fetch_misalign_q <= fetch_misalign_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (instr_ready),
        .head_o     (head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign instr_valid    = !fifo_empty;
    assign instr          = fifo_empty ? '0 : head.instr;
    assign instr_pc       = fifo_empty ? '0 : head.pc;
    assign selector       = instr[6:2];
    assign fetch_misalign = fetch_misalign_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench with a queue-based memory and delivery model.
module tb_instr_fetch_unit;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid, instr_valid, instr_ready, fetch_misalign;
    logic [31:0] redirect_pc, instr, instr_pc;
    logic [4:0]  selector;

    instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .selector(selector), .fetch_misalign(fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       memq[$];
    mreq_t       m_tmp;
    logic [31:0] acc_log[$], pop_log[$];
    logic [4:0]  sel_log[$];
    int          acc_cyc[$], pop_cyc[$];

    int compared = 0, mismatched = 0;
    int cyc = 0, buffered = 0, stale = 0, boot_cyc = 0, total_pops = 0;
    bit boot = 1, rst_seen = 0, hold_rsp = 0;
    logic [31:0] exp_pc = RST_PC, exp_req = RST_PC, w;
    logic        exp_mis = 0;
    int ready_pct = 100, iready_pct = 100, lat_extra = 0, redir_pct = 0;

    // low addresses hold NOPs; elsewhere an odd-multiplier hash gives every address a unique word
    function automatic logic [31:0] word(input logic [31:0] a);
        return a < 32'h40 ? 32'h0000_0013 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // model: memory queue, stale-response count and buffered-word count, updated once per cycle
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            if (rst_seen) begin
                chk("rst_req_valid", 32'(imem_req_valid), 0);
                chk("rst_instr_valid", 32'(instr_valid), 0);
                chk("rst_instr", instr, 0);
                chk("rst_instr_pc", instr_pc, 0);
                chk("rst_selector", 32'(selector), 0);
                chk("rst_misalign", 32'(fetch_misalign), 0);
            end
            memq.delete();
            buffered = 0; stale = 0; exp_pc = RST_PC; exp_req = RST_PC; exp_mis = 0;
            boot = 1; rst_seen = 1;
        end else begin
            rst_seen = 0;
            chk("req_valid", 32'(imem_req_valid), 32'(!boot && stale == 0 && memq.size() + buffered < DEPTH));
            chk("instr_valid", 32'(instr_valid), 32'(buffered != 0));
            chk("misalign", 32'(fetch_misalign), 32'(exp_mis));
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
            if (buffered != 0) begin
                w = word(exp_pc);
                chk("head_pc", instr_pc, exp_pc);
                chk("head_instr", instr, w);
                chk("selector", 32'(selector), 32'(w[6:2]));
                if (instr_ready) begin
                    pop_log.push_back(instr_pc);
                    sel_log.push_back(selector);
                    pop_cyc.push_back(cyc);
                    exp_pc += 4;
                    buffered--;
                    total_pops++;
                end
            end
            if (imem_rsp_valid && memq.size() != 0) begin
                m_tmp = memq.pop_front();
                if (stale != 0) stale--;
                else buffered++;
            end
            if (imem_req_valid && imem_req_ready) begin
                m_tmp.addr = imem_req_addr;
                m_tmp.due  = cyc + 1 + int'($urandom_range(lat_extra));
                memq.push_back(m_tmp);
                acc_log.push_back(imem_req_addr);
                acc_cyc.push_back(cyc);
                exp_req += 4;
            end
            if (redirect_valid && !boot) begin
                buffered = 0;
                stale    = memq.size();
                exp_pc   = {redirect_pc[31:2], 2'b00};
                exp_req  = exp_pc;
                exp_mis  = |redirect_pc[1:0];
            end
            if (boot) boot_cyc = cyc;
            boot = 0;
        end
    end

    task automatic tick(input bit rdv = 1'b0, input logic [31:0] rdpc = 32'h0);
        @(posedge clk);
        #1;
        imem_req_ready = $urandom_range(99) < ready_pct;
        instr_ready    = $urandom_range(99) < iready_pct;
        if (rst_n && !hold_rsp && memq.size() != 0 && memq[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirect_valid = rdv || ($urandom_range(99) < redir_pct);
        redirect_pc    = rdv ? rdpc : $urandom;
    endtask

    initial begin
        int n, p0;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (14) tick();
        if (acc_log.size() >= 3 && pop_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("p1_req_addr", acc_log[i], 32'(i * 4));
                chk("p1_instr_pc", pop_log[i], 32'(i * 4));
                chk("p1_selector", 32'(sel_log[i]), 32'b00100);
            end
            chk("p1_first_req_after_boot", 32'(acc_cyc[0] - boot_cyc), 1);
            chk("p1_fetch_latency", 32'(pop_cyc[0] - acc_cyc[0]), 2);
        end else chk("p1_counts", 32'(acc_log.size() >= 3 && pop_log.size() >= 3), 1);

        acc_log.delete();
        iready_pct = 0;
        repeat (10) tick();
        @(negedge clk);
        #1;
        n = acc_log.size();
        chk("p2_stall_reqs_le_depth", 32'(n <= DEPTH), 1);
        iready_pct = 100;
        repeat (10) tick();

        lat_extra = 2;
        hold_rsp = 1;
        for (int i = 0; i < 20 && memq.size() != 2; i++) tick();
        chk("p3_two_in_flight", memq.size(), 2);
        tick(1'b1, 32'h100);
        hold_rsp = 0;
        tick();
        pop_log.delete();
        repeat (20) tick();
        chk("p3_has_pops", 32'(pop_log.size() != 0), 1);
        if (pop_log.size() != 0) chk("p3_first_pc", pop_log[0], 32'h100);

        tick(1'b1, 32'h102);
        tick();
        acc_log.delete();
        chk("p4_misalign_set", 32'(fetch_misalign), 1);
        repeat (15) tick();
        chk("p4_has_reqs", 32'(acc_log.size() != 0), 1);
        if (acc_log.size() != 0) chk("p4_req_addr", acc_log[0], 32'h100);
        tick(1'b1, 32'h200);
        tick();
        chk("p4_misalign_clear", 32'(fetch_misalign), 0);

        tick(1'b1, 32'hFFFF_FFF8);
        tick();
        acc_log.delete();
        repeat (20) tick();
        if (acc_log.size() >= 3) begin
            chk("p5_addr0", acc_log[0], 32'hFFFF_FFF8);
            chk("p5_addr1", acc_log[1], 32'hFFFF_FFFC);
            chk("p5_addr2", acc_log[2], 32'h0000_0000);
        end else chk("p5_count", acc_log.size(), 3);

        hold_rsp = 1;
        for (int i = 0; i < 20 && memq.size() != 2; i++) tick();
        chk("p6_two_in_flight", memq.size(), 2);
        rst_n = 1'b0;
        repeat (3) tick();
        hold_rsp = 0;
        rst_n = 1'b1;
        pop_log.delete();
        repeat (12) tick();
        chk("p6_has_pops", 32'(pop_log.size() != 0), 1);
        if (pop_log.size() != 0) chk("p6_first_pc", pop_log[0], RST_PC);

        ready_pct = 50; iready_pct = 70; lat_extra = 3; redir_pct = 3;
        p0 = total_pops;
        repeat (3000) tick();
        redir_pct = 0;
        repeat (20) tick();
        chk("random_liveness", 32'(total_pops - p0 > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
